vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 141 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parameterised VGA-style raster timing generator: free-running h/v counters
// advanced by a pixel-rate enable, with registered sync, blanking and coordinate outputs.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int CW       = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pix_en,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL     = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL     = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int H_ACT_START = H_SYNC + H_BACK;
  localparam int V_ACT_START = V_SYNC + V_BACK;
  localparam int H_ACT_END   = H_ACT_START + H_ACTIVE;
  localparam int V_ACT_END   = V_ACT_START + V_ACTIVE;

  // Region bounds are compared one bit wider so a total of exactly 2^CW
  // still has representable end points.
  localparam logic [CW:0] H_SYNC_END_W  = (CW+1)'(H_SYNC);
  localparam logic [CW:0] H_ACT_START_W = (CW+1)'(H_ACT_START);
  localparam logic [CW:0] H_ACT_END_W   = (CW+1)'(H_ACT_END);
  localparam logic [CW:0] H_LAST_W      = (CW+1)'(H_TOTAL - 1);
  localparam logic [CW:0] V_SYNC_END_W  = (CW+1)'(V_SYNC);
  localparam logic [CW:0] V_ACT_START_W = (CW+1)'(V_ACT_START);
  localparam logic [CW:0] V_ACT_END_W   = (CW+1)'(V_ACT_END);
  localparam logic [CW:0] V_LAST_W      = (CW+1)'(V_TOTAL - 1);

  localparam logic [CW-1:0] H_ACT_START_C = CW'(H_ACT_START);
  localparam logic [CW-1:0] V_ACT_START_C = CW'(V_ACT_START);
  localparam logic [CW-1:0] ONE_C         = CW'(1);

  logic [CW-1:0] h_reg, h_next;
  logic [CW-1:0] v_reg, v_next;
  logic [CW:0]   h_ext, v_ext;

  logic          hsync_reg, hsync_next;
  logic          vsync_reg, vsync_next;
  logic          de_reg, de_next;
  logic [CW-1:0] x_reg, x_next;
  logic [CW-1:0] y_reg, y_next;
  logic          line_start_reg, line_start_next;
  logic          frame_start_reg, frame_start_next;

  logic h_sync_zone, h_act_zone, h_at_last, h_at_act_start;
  logic v_sync_zone, v_act_zone, v_at_last, v_at_act_start;

  assign h_ext = {1'b0, h_reg};
  assign v_ext = {1'b0, v_reg};

  always_comb begin
    h_sync_zone    = (h_ext < H_SYNC_END_W);
    h_act_zone     = (h_ext >= H_ACT_START_W) && (h_ext < H_ACT_END_W);
    h_at_last      = (h_ext == H_LAST_W);
    h_at_act_start = (h_ext == H_ACT_START_W);
    v_sync_zone    = (v_ext < V_SYNC_END_W);
    v_act_zone     = (v_ext >= V_ACT_START_W) && (v_ext < V_ACT_END_W);
    v_at_last      = (v_ext == V_LAST_W);
    v_at_act_start = (v_ext == V_ACT_START_W);
  end

  // Counter advance: v steps only on the h wrap.
  always_comb begin
    h_next = h_reg + ONE_C;
    v_next = v_reg;
    if (h_at_last) begin
      h_next = '0;
      if (v_at_last) begin
        v_next = '0;
      end else begin
        v_next = v_reg + ONE_C;
      end
    end
  end

  // Output decode from the pre-increment counter values.
  always_comb begin
    hsync_next       = h_sync_zone ? H_POL : ~H_POL;
    vsync_next       = v_sync_zone ? V_POL : ~V_POL;
    de_next          = h_act_zone && v_act_zone;
    x_next           = h_act_zone ? (h_reg - H_ACT_START_C) : '0;
    y_next           = v_act_zone ? (v_reg - V_ACT_START_C) : '0;
    line_start_next  = h_at_act_start && v_act_zone;
    frame_start_next = h_at_act_start && v_at_act_start;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_reg           <= '0;
      v_reg           <= '0;
      hsync_reg       <= ~H_POL;
      vsync_reg       <= ~V_POL;
      de_reg          <= 1'b0;
      x_reg           <= '0;
      y_reg           <= '0;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      // Pulses last one clk regardless of whether the next cycle is enabled.
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
      if (pix_en) begin
        h_reg           <= h_next;
        v_reg           <= v_next;
        hsync_reg       <= hsync_next;
        vsync_reg       <= vsync_next;
        de_reg          <= de_next;
        x_reg           <= x_next;
        y_reg           <= y_next;
        line_start_reg  <= line_start_next;
        frame_start_reg <= frame_start_next;
      end
    end
  end

  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign de          = de_reg;
  assign x           = x_reg;
  assign y           = y_reg;
  assign line_start  = line_start_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three parameter sets driven with shared random
// enable/reset stimulus and checked every cycle against a raster-position model.
module tb_vga_timing_gen;

  typedef struct {
    bit hs;
    bit vs;
    bit de;
    int x;
    int y;
    bit ls;
    bit fs;
  } vout_t;

  logic clk;
  logic reset;
  logic pix_en;
  logic s_rst, s_pe;

  int errors = 0;
  int checks = 0;

  logic       hsync_a, vsync_a, de_a, ls_a, fs_a;
  logic [9:0] x_a, y_a;
  logic       hsync_b, vsync_b, de_b, ls_b, fs_b;
  logic [9:0] x_b, y_b;
  logic       hsync_c, vsync_c, de_c, ls_c, fs_c;
  logic [4:0] x_c, y_c;

  vga_timing_gen dut_a (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .hsync(hsync_a), .vsync(vsync_a), .de(de_a), .x(x_a), .y(y_a),
    .line_start(ls_a), .frame_start(fs_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_ACTIVE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_POL(1'b1), .V_POL(1'b1), .CW(10)
  ) dut_b (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .hsync(hsync_b), .vsync(vsync_b), .de(de_b), .x(x_b), .y(y_b),
    .line_start(ls_b), .frame_start(fs_b)
  );

  vga_timing_gen #(
    .H_ACTIVE(10), .H_FRONT(3), .H_SYNC(2), .H_BACK(4),
    .V_ACTIVE(6), .V_FRONT(2), .V_SYNC(1), .V_BACK(3),
    .H_POL(1'b0), .V_POL(1'b0), .CW(5)
  ) dut_c (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .hsync(hsync_c), .vsync(vsync_c), .de(de_c), .x(x_c), .y(y_c),
    .line_start(ls_c), .frame_start(fs_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Outputs after the n-th enabled cycle (counted from 0) since reset.
  function automatic vout_t model(int n, int ha, int hf, int hsw, int hb,
                                  int va, int vf, int vsw, int vb, bit hp, bit vp);
    vout_t e;
    int ht, vt, h, v;
    bit hact, vact;
    ht   = hsw + hb + ha + hf;
    vt   = vsw + vb + va + vf;
    h    = n % ht;
    v    = (n / ht) % vt;
    hact = (h >= hsw + hb) && (h < hsw + hb + ha);
    vact = (v >= vsw + vb) && (v < vsw + vb + va);
    e.hs = (h < hsw) ? hp : !hp;
    e.vs = (v < vsw) ? vp : !vp;
    e.de = hact && vact;
    e.x  = hact ? h - (hsw + hb) : 0;
    e.y  = vact ? v - (vsw + vb) : 0;
    e.ls = (h == hsw + hb) && vact;
    e.fs = (h == hsw + hb) && (v == vsw + vb);
    return e;
  endfunction

  function automatic vout_t model_a(int n);
    return model(n, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
  endfunction
  function automatic vout_t model_b(int n);
    return model(n, 4, 1, 1, 1, 2, 1, 1, 1, 1'b1, 1'b1);
  endfunction
  function automatic vout_t model_c(int n);
    return model(n, 10, 3, 2, 4, 6, 2, 1, 3, 1'b0, 1'b0);
  endfunction

  function automatic vout_t reset_val(bit hp, bit vp);
    vout_t e;
    e.hs = !hp; e.vs = !vp; e.de = 1'b0;
    e.x = 0; e.y = 0; e.ls = 1'b0; e.fs = 1'b0;
    return e;
  endfunction

  task automatic cmp(string name, vout_t e, vout_t a);
    checks++;
    if (e.hs != a.hs || e.vs != a.vs || e.de != a.de || e.x != a.x ||
        e.y != a.y || e.ls != a.ls || e.fs != a.fs) begin
      errors++;
      $display("FAIL %s t=%0t got hs=%0b vs=%0b de=%0b x=%0d y=%0d ls=%0b fs=%0b want hs=%0b vs=%0b de=%0b x=%0d y=%0d ls=%0b fs=%0b",
               name, $time, a.hs, a.vs, a.de, a.x, a.y, a.ls, a.fs,
               e.hs, e.vs, e.de, e.x, e.y, e.ls, e.fs);
    end
  endtask

  task automatic pin(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  always @(posedge clk) begin
    s_rst <= reset;
    s_pe  <= pix_en;
  end

  // Single compare process: every cycle after the first reset.
  int    n_a = 0, n_b = 0, n_c = 0;
  bit    armed = 1'b0;
  vout_t exp_a, exp_b, exp_c, act;

  always @(negedge clk) begin
    if (s_rst === 1'b1) begin
      n_a = 0; n_b = 0; n_c = 0;
      exp_a = reset_val(1'b0, 1'b0);
      exp_b = reset_val(1'b1, 1'b1);
      exp_c = reset_val(1'b0, 1'b0);
      armed = 1'b1;
    end else if (armed) begin
      if (s_pe === 1'b1) begin
        exp_a = model_a(n_a); n_a++;
        exp_b = model_b(n_b); n_b++;
        exp_c = model_c(n_c); n_c++;
      end else begin
        exp_a.ls = 1'b0; exp_a.fs = 1'b0;
        exp_b.ls = 1'b0; exp_b.fs = 1'b0;
        exp_c.ls = 1'b0; exp_c.fs = 1'b0;
      end
    end
    if (armed) begin
      act.hs = hsync_a; act.vs = vsync_a; act.de = de_a;
      act.x = int'(x_a); act.y = int'(y_a); act.ls = ls_a; act.fs = fs_a;
      cmp("default", exp_a, act);
      act.hs = hsync_b; act.vs = vsync_b; act.de = de_b;
      act.x = int'(x_b); act.y = int'(y_b); act.ls = ls_b; act.fs = fs_b;
      cmp("tiny_pol1", exp_b, act);
      act.hs = hsync_c; act.vs = vsync_c; act.de = de_c;
      act.x = int'(x_c); act.y = int'(y_c); act.ls = ls_c; act.fs = fs_c;
      cmp("small_cw5", exp_c, act);
    end
  end

  task automatic drive(bit r, bit pe);
    reset  = r;
    pix_en = pe;
    @(posedge clk);
    #1;
  endtask

  vout_t m;

  initial begin
    reset  = 1'b1;
    pix_en = 1'b0;

    // Hand-computed expectations pinning the model itself.
    m = model_a(0);               pin("m_a0_hs", m.hs, 0); pin("m_a0_vs", m.vs, 0); pin("m_a0_de", m.de, 0);
    m = model_a(95);              pin("m_a95_hs", m.hs, 0);
    m = model_a(96);              pin("m_a96_hs", m.hs, 1);
    m = model_a(1599);            pin("m_a1599_vs", m.vs, 0);
    m = model_a(1600);            pin("m_a1600_vs", m.vs, 1);
    m = model_a(35*800+144);      pin("m_a_first_de", m.de, 1); pin("m_a_first_ls", m.ls, 1);
                                  pin("m_a_first_fs", m.fs, 1); pin("m_a_first_x", m.x, 0);
    m = model_a(36*800+144+639);  pin("m_a_x639", m.x, 639); pin("m_a_y1", m.y, 1);
                                  pin("m_a_ls_mid", m.ls, 0);
    m = model_a(36*800+784);      pin("m_a_front_de", m.de, 0); pin("m_a_front_x", m.x, 0);
                                  pin("m_a_front_y", m.y, 1);
    m = model_a(515*800+200);     pin("m_a_vfront_y", m.y, 0); pin("m_a_vfront_x", m.x, 56);
    m = model_a(420000);          pin("m_a_wrap_vs", m.vs, 0);
    m = model_b(1);               pin("m_b1_hs", m.hs, 0); pin("m_b1_vs", m.vs, 1);
    m = model_b(2*7+2);           pin("m_b_fs", m.fs, 1); pin("m_b_de", m.de, 1);
    m = model_b(3*7+5);           pin("m_b_x", m.x, 3); pin("m_b_y", m.y, 1);
    m = model_b(35);              pin("m_b_wrap_vs", m.vs, 1); pin("m_b_wrap_de", m.de, 0);

    repeat (3) drive(1'b1, 1'b0);
    pin("rst_hsync_a", int'(hsync_a), 1);
    pin("rst_vsync_b", int'(vsync_b), 0);
    drive(1'b0, 1'b1);
    pin("first_hsync_a", int'(hsync_a), 0);
    pin("first_vsync_a", int'(vsync_a), 0);
    pin("first_de_a", int'(de_a), 0);
    pin("first_hsync_b", int'(hsync_b), 1);

    // Continuous enable, with one deterministic mid-run reset.
    repeat (1234) drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    repeat (3000) drive(1'b0, 1'b1);

    // Enable toggling 1,0.
    for (int i = 0; i < 2000; i++) drive(1'b0, (i % 2) == 0);

    // Random enable with sparse random resets.
    for (int i = 0; i < 15000; i++)
      drive($urandom_range(0, 999) == 0, $urandom_range(0, 3) != 0);

    // Long continuous run so the default raster enters its active lines.
    drive(1'b1, 1'b0);
    repeat (50000) drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    pin("midframe_rst_de_a", int'(de_a), 0);
    pin("midframe_rst_x_a", int'(x_a), 0);
    repeat (100) drive(1'b0, 1'b1);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
